srreg_arbiter: RTL and testbench

SRREG_ARBITER -- requirements
Module: srreg_arbiter

---
 rtl/srreg_arbiter.sv | 117 +++++++++++
 tb/tb_srreg_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/srreg_arbiter.sv
// srreg_arbiter: round-robin arbiter granting N requesters load/set/clear/hold access to one shared register
// Optional feature macro: SRREG_ARB_TIMEOUT_EN. When it is defined, RELEASE gives up after 16 cycles.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[N]          level requests, held until ack
//   op[2N]          per-requester opcode {00 load, 01 set, 10 clear, 11 hold}
//   din[WIDTH*N]    per-requester load data
//   sclr            synchronous clear of q, overrides any committed op
//   gnt[N]          one-hot grant, held through GRANT and RELEASE
//   ack             one-cycle pulse when the granted op commits
//   q[WIDTH]        shared register
//   busy            FSM not in IDLE
//   timeout         one-cycle pulse when a RELEASE times out
module srreg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [2*N-1:0]     op,
    input  logic [WIDTH*N-1:0] din,
    input  logic               sclr,
    output logic [N-1:0]       gnt,
    output logic               ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               timeout
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic             r_ack;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic [N-1:0]     w_rot;
    logic [IW-1:0]    w_off;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_next;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_din;
    int               w_sum;
    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the winner's offset.
    always_comb begin
        w_rot = N'({req, req} >> r_ptr);
        w_off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) w_off = IW'(k);
        w_sum = int'(r_ptr) + int'(w_off);
        w_win = IW'(w_sum >= N ? w_sum - N : w_sum);
    end
    assign w_next = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
    assign w_op   = op[2*r_idx +: 2];
    assign w_din  = din[WIDTH*r_idx +: WIDTH];
`ifdef SRREG_ARB_TIMEOUT_EN
    logic [3:0] r_cnt;
    logic       r_timeout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_cnt     <= (r_state == RELEASE) ? r_cnt + 4'd1 : '0;
            if (r_state == RELEASE && req[r_idx] && r_cnt == 4'd15)
                r_timeout <= 1'b1;
        end
    end
    assign timeout = r_timeout;
    wire w_rel_done = !req[r_idx] || r_cnt == 4'd15;
`else
    assign timeout = 1'b0;
    wire w_rel_done = !req[r_idx];
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= 1'b0;
            r_q     <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            r_q <= sclr ? '0 :
                   (r_state != GRANT) ? r_q :
                   (w_op == 2'b00) ? w_din :
                   (w_op == 2'b01) ? {WIDTH{1'b1}} :
                   (w_op == 2'b10) ? '0 : r_q;
            case (r_state)
                IDLE: if (|req) begin
                    r_state <= GRANT;
                    r_gnt   <= N'(1) << w_win;
                    r_idx   <= w_win;
                end
                GRANT: begin
                    r_state <= RELEASE;
                    r_ack   <= 1'b1;
                end
                RELEASE: begin
                    r_ack <= 1'b0;
                    if (w_rel_done) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign q    = r_q;
    assign busy = r_state != IDLE;
endmodule

// File: tb/tb_srreg_arbiter.sv
// tb_srreg_arbiter: directed vector table plus reset and timeout sequences for srreg_arbiter
module tb_srreg_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [7:0]  op = 8'hFF;
    logic [31:0] din = '0;
    logic        sclr = 1'b0;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  q;
    logic        busy;
    logic        timeout;
    int          checks = 0;
    int          errors = 0;

    srreg_arbiter #(.N(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .din(din), .sclr(sclr),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] din;
        logic        sclr;
        logic [3:0]  gnt;
        logic        ack;
        logic [7:0]  q;
        logic        busy;
    } vec_t;

    vec_t v[31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [7:0] o, input logic [31:0] d, input logic s);
        req = r;
        op = o;
        din = d;
        sclr = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, req, op, din, sclr | gnt, ack, q, busy
        v[0]  = '{1'b1, 4'b0000, 8'hFC, 32'h000000A5, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
        v[1]  = '{1'b0, 4'b0001, 8'hFC, 32'h000000A5, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1};
        v[2]  = '{1'b0, 4'b0001, 8'hFC, 32'h000000A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1};
        v[3]  = '{1'b0, 4'b0000, 8'hFC, 32'h000000A5, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0};
        v[4]  = '{1'b0, 4'b0000, 8'hFC, 32'h000000A5, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0};
        v[5]  = '{1'b1, 4'b0000, 8'hC9, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
        v[6]  = '{1'b0, 4'b1111, 8'hC9, 32'h003C0000, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1};
        v[7]  = '{1'b0, 4'b1111, 8'hC9, 32'h003C0000, 1'b0, 4'b0001, 1'b1, 8'hFF, 1'b1};
        v[8]  = '{1'b0, 4'b1110, 8'hC9, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 8'hFF, 1'b0};
        v[9]  = '{1'b0, 4'b1110, 8'hC9, 32'h003C0000, 1'b0, 4'b0010, 1'b0, 8'hFF, 1'b1};
        v[10] = '{1'b0, 4'b1110, 8'hC9, 32'h003C0000, 1'b0, 4'b0010, 1'b1, 8'h00, 1'b1};
        v[11] = '{1'b0, 4'b1100, 8'hC9, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
        v[12] = '{1'b0, 4'b1100, 8'hC9, 32'h003C0000, 1'b0, 4'b0100, 1'b0, 8'h00, 1'b1};
        v[13] = '{1'b0, 4'b1100, 8'hC9, 32'h003C0000, 1'b0, 4'b0100, 1'b1, 8'h3C, 1'b1};
        v[14] = '{1'b0, 4'b1000, 8'hC9, 32'h003C0000, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b0};
        v[15] = '{1'b0, 4'b1000, 8'hC9, 32'h003C0000, 1'b0, 4'b1000, 1'b0, 8'h3C, 1'b1};
        v[16] = '{1'b0, 4'b1000, 8'hC9, 32'h003C0000, 1'b0, 4'b1000, 1'b1, 8'h3C, 1'b1};
        v[17] = '{1'b0, 4'b0001, 8'hC8, 32'h003C000F, 1'b0, 4'b0000, 1'b0, 8'h3C, 1'b0};
        v[18] = '{1'b0, 4'b0001, 8'hC8, 32'h003C000F, 1'b0, 4'b0001, 1'b0, 8'h3C, 1'b1};
        v[19] = '{1'b0, 4'b0001, 8'hC8, 32'h003C000F, 1'b0, 4'b0001, 1'b1, 8'h0F, 1'b1};
        v[20] = '{1'b0, 4'b0000, 8'hC8, 32'h003C000F, 1'b0, 4'b0000, 1'b0, 8'h0F, 1'b0};
        v[21] = '{1'b0, 4'b0100, 8'hD8, 32'h003C000F, 1'b0, 4'b0100, 1'b0, 8'h0F, 1'b1};
        v[22] = '{1'b0, 4'b0100, 8'hD8, 32'h003C000F, 1'b1, 4'b0100, 1'b1, 8'h00, 1'b1};
        v[23] = '{1'b0, 4'b0000, 8'hD8, 32'h003C000F, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
        v[24] = '{1'b0, 4'b0010, 8'hD0, 32'h003C5A0F, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b1};
        v[25] = '{1'b0, 4'b0000, 8'hD0, 32'h003C5A0F, 1'b0, 4'b0010, 1'b1, 8'h5A, 1'b1};
        v[26] = '{1'b0, 4'b0000, 8'hD0, 32'h003C5A0F, 1'b0, 4'b0000, 1'b0, 8'h5A, 1'b0};
        v[27] = '{1'b0, 4'b1000, 8'h50, 32'h003C5A0F, 1'b0, 4'b1000, 1'b0, 8'h5A, 1'b1};
        v[28] = '{1'b0, 4'b1000, 8'h50, 32'h003C5A0F, 1'b0, 4'b1000, 1'b1, 8'hFF, 1'b1};
        v[29] = '{1'b0, 4'b1001, 8'h90, 32'h003C5A0F, 1'b0, 4'b1000, 1'b0, 8'hFF, 1'b1};
        v[30] = '{1'b0, 4'b0000, 8'h90, 32'h003C5A0F, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};
        #3;
        for (int i = 0; i < 31; i++) begin
            rst_n = !v[i].rst;
            cyc(v[i].req, v[i].op, v[i].din, v[i].sclr);
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(v[i].ack));
            chk($sformatf("v%0d_q", i), 32'(q), 32'(v[i].q));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].busy));
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
        end
        rst_n = 1'b1;
        // advance rr_ptr to 1, then reset during a pending load of 8'h77 by requester 2
        cyc(4'b0001, 8'hFF, 32'h0, 1'b0);
        cyc(4'b0001, 8'hFF, 32'h0, 1'b0);
        cyc(4'b0000, 8'hFF, 32'h0, 1'b0);
        chk("pre_rst_idle_gnt", 32'(gnt), 32'h0);
        cyc(4'b0100, 8'hCF, 32'h00770000, 1'b0);
        chk("pre_rst_grant_gnt", 32'(gnt), 32'h4);
        chk("pre_rst_grant_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", 32'(q), 32'h0);
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_ack", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_q", 32'(q), 32'h0);
        rst_n = 1'b1;
        cyc(4'b0101, 8'hCF, 32'h00770000, 1'b0);
        chk("post_rst_winner", 32'(gnt), 32'h1);
        cyc(4'b0101, 8'hCF, 32'h00770000, 1'b0);
        chk("post_rst_ack", 32'(ack), 32'h1);
        chk("post_rst_q", 32'(q), 32'h0);
        cyc(4'b0000, 8'hFF, 32'h0, 1'b0);
        chk("post_rst_idle", 32'(busy), 32'h0);
        // requester 1 holds req for 20 cycles after ack while requester 2 waits
        cyc(4'b0110, 8'hFF, 32'h0, 1'b0);
        chk("to_grant", 32'(gnt), 32'h2);
        cyc(4'b0110, 8'hFF, 32'h0, 1'b0);
        chk("to_ack", 32'(ack), 32'h1);
        for (int i = 1; i <= 20; i++) begin
            logic [3:0] eg;
            logic       et;
`ifdef SRREG_ARB_TIMEOUT_EN
            eg = (i < 16) ? 4'b0010 : (i == 16) ? 4'b0000 : 4'b0100;
            et = (i == 16);
`else
            eg = 4'b0010;
            et = 1'b0;
`endif
            cyc(4'b0110, 8'hFF, 32'h0, 1'b0);
            chk($sformatf("to%0d_gnt", i), 32'(gnt), 32'(eg));
            chk($sformatf("to%0d_timeout", i), 32'(timeout), 32'(et));
        end
        cyc(4'b0000, 8'hFF, 32'h0, 1'b0);
        cyc(4'b0000, 8'hFF, 32'h0, 1'b0);
        chk("final_busy", 32'(busy), 32'h0);
        chk("final_gnt", 32'(gnt), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
